// File: rtl/memory_ice40_spram_banked.sv
// rtl/memory_ice40_spram_banked.sv - banked iCE40 SPRAM main memory with valid/ready port and idle sleep manager
// ice40_spram mirrors the SB_SPRAM256KA pin set; the top stacks pairs of them into 32-bit banks.

module ice40_spram (
    input  logic        clock,
    input  logic [13:0] address,
    input  logic [15:0] datain,
    input  logic [3:0]  maskwren,
    input  logic        wren,
    input  logic        chipselect,
    input  logic        standby,
    input  logic        sleep,
    input  logic        poweroff,
    output logic [15:0] dataout
);
    logic [15:0] mem [16384];
    logic [15:0] dataout_q;
    logic [15:0] dataout_d;
    logic [15:0] wr_word;
    logic        powered;

    assign powered = !sleep && !standby && poweroff;
    assign dataout = dataout_q;

    always_comb begin
        wr_word   = mem[address];
        dataout_d = dataout_q;
        for (int n = 0; n < 4; n++) begin
            if (maskwren[n]) begin
                wr_word[4*n +: 4] = datain[4*n +: 4];
            end
        end
        if (chipselect && powered && !wren) begin
            dataout_d = mem[address];
        end
    end

    always_ff @(posedge clock) begin
        if (chipselect && powered && wren) begin
            mem[address] <= wr_word;
        end
        dataout_q <= dataout_d;
    end
endmodule

module memory_ice40_spram_banked #(
    parameter int NUM_BANKS   = 2,
    parameter int ADDR_W      = 15,
    parameter int OUTPUT_REG  = 0,
    parameter int IDLE_CYCLES = 256,
    parameter int WAKE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    output logic              ready,
    input  logic              wen,
    input  logic [3:0]        wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              sleeping
);
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int NUM_SLOTS = 1 << BANK_W;
    localparam int IDLE_W    = $clog2(IDLE_CYCLES + 2);
    localparam int WAKE_W    = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [WAKE_W-1:0]   wake_q, wake_d;
    logic                rd_v_q, rd_v_d;
    logic                out_v_q, out_v_d;
    logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
    logic [31:0]         hold_q, hold_d;

    logic                accept;
    logic                sleep_pin;
    logic [BANK_W-1:0]   bank_idx;
    logic [31:0]         rd_word;
    logic [31:0]         bank_dout [NUM_SLOTS];

    assign ready     = (state_q == ST_ACTIVE);
    assign sleeping  = (state_q == ST_SLEEP);
    assign sleep_pin = (state_q == ST_SLEEP);
    assign accept    = valid && ready && !reset;

    generate
        if (NUM_BANKS > 1) begin : g_bank_idx
            assign bank_idx = addr[ADDR_W-1:14];
        end else begin : g_single_bank
            assign bank_idx = 1'b0;
        end
    endgenerate

    // Unpopulated slots read as zero, so an out-of-range read returns 0 and a write there selects nothing.
    genvar b;
    generate
        for (b = 0; b < NUM_SLOTS; b++) begin : g_bank
            if (b < NUM_BANKS) begin : g_pop
                logic cs;
                logic [15:0] dout_hi, dout_lo;
                assign cs = accept && (bank_idx == BANK_W'(b));

                ice40_spram u_hi (
                    .clock      (clk),
                    .address    (addr[13:0]),
                    .datain     (wdata[31:16]),
                    .maskwren   ({wmask[3], wmask[3], wmask[2], wmask[2]}),
                    .wren       (wen),
                    .chipselect (cs),
                    .standby    (1'b0),
                    .sleep      (sleep_pin),
                    .poweroff   (1'b1),
                    .dataout    (dout_hi)
                );

                ice40_spram u_lo (
                    .clock      (clk),
                    .address    (addr[13:0]),
                    .datain     (wdata[15:0]),
                    .maskwren   ({wmask[1], wmask[1], wmask[0], wmask[0]}),
                    .wren       (wen),
                    .chipselect (cs),
                    .standby    (1'b0),
                    .sleep      (sleep_pin),
                    .poweroff   (1'b1),
                    .dataout    (dout_lo)
                );

                assign bank_dout[b] = {dout_hi, dout_lo};
            end else begin : g_empty
                assign bank_dout[b] = 32'h0;
            end
        end
    endgenerate

    assign rd_word = bank_dout[rd_bank_q];

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        wake_d    = wake_q;
        rd_v_d    = accept && !wen;
        rd_bank_d = (accept && !wen) ? bank_idx : rd_bank_q;
        out_v_d   = rd_v_q;
        hold_d    = rd_v_q ? rd_word : hold_q;

        case (state_q)
            ST_ACTIVE: begin
                if (accept) begin
                    idle_d = '0;
                end else begin
                    if (idle_q != '1) begin
                        idle_d = idle_q + 1'b1;
                    end
                    if (IDLE_CYCLES != 0 && idle_d >= IDLE_W'(IDLE_CYCLES) && !rd_v_q && !out_v_q) begin
                        state_d = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                if (valid) begin
                    state_d = ST_WAKE;
                    wake_d  = WAKE_W'(WAKE_CYCLES);
                end
            end
            ST_WAKE: begin
                if (wake_q != '0) begin
                    wake_d = wake_q - 1'b1;
                end
                if (wake_d == '0) begin
                    state_d = ST_ACTIVE;
                    idle_d  = '0;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ACTIVE;
            idle_q    <= '0;
            wake_q    <= '0;
            rd_v_q    <= 1'b0;
            out_v_q   <= 1'b0;
            rd_bank_q <= '0;
            hold_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            wake_q    <= wake_d;
            rd_v_q    <= rd_v_d;
            out_v_q   <= out_v_d;
            rd_bank_q <= rd_bank_d;
            hold_q    <= hold_d;
        end
    end

    // Unregistered mode passes the SPRAM word straight through on the return cycle and holds it afterwards.
    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            assign rvalid = out_v_q;
            assign rdata  = hold_q;
        end else begin : g_out_comb
            assign rvalid = rd_v_q;
            assign rdata  = rd_v_q ? rd_word : hold_q;
        end
    endgenerate
endmodule

// File: tb/tb_memory_ice40_spram_banked.sv
// tb/tb_memory_ice40_spram_banked.sv - directed-vector bench for memory_ice40_spram_banked

module tb_memory_ice40_spram_banked;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic        valid_a = 0, wen_a = 0, ready_a, rvalid_a, sleeping_a;
    logic [3:0]  wmask_a = 0;
    logic [14:0] addr_a = 0;
    logic [31:0] wdata_a = 0, rdata_a;

    logic        valid_b = 0, wen_b = 0, ready_b, rvalid_b, sleeping_b;
    logic [3:0]  wmask_b = 0;
    logic [14:0] addr_b = 0;
    logic [31:0] wdata_b = 0, rdata_b;

    logic        valid_c = 0, wen_c = 0, ready_c, rvalid_c, sleeping_c;
    logic [3:0]  wmask_c = 0;
    logic [15:0] addr_c = 0;
    logic [31:0] wdata_c = 0, rdata_c;

    memory_ice40_spram_banked #(.NUM_BANKS(2), .ADDR_W(15), .OUTPUT_REG(0), .IDLE_CYCLES(8), .WAKE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .valid(valid_a), .ready(ready_a), .wen(wen_a), .wmask(wmask_a),
        .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .rvalid(rvalid_a), .sleeping(sleeping_a));

    memory_ice40_spram_banked #(.NUM_BANKS(2), .ADDR_W(15), .OUTPUT_REG(1), .IDLE_CYCLES(0), .WAKE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .valid(valid_b), .ready(ready_b), .wen(wen_b), .wmask(wmask_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .rvalid(rvalid_b), .sleeping(sleeping_b));

    memory_ice40_spram_banked #(.NUM_BANKS(3), .ADDR_W(16), .OUTPUT_REG(0), .IDLE_CYCLES(0), .WAKE_CYCLES(4)) dut_c (
        .clk(clk), .reset(reset), .valid(valid_c), .ready(ready_c), .wen(wen_c), .wmask(wmask_c),
        .addr(addr_c), .wdata(wdata_c), .rdata(rdata_c), .rvalid(rvalid_c), .sleeping(sleeping_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic v, input logic w, input logic [3:0] m, input logic [14:0] a, input logic [31:0] d);
        valid_a = v; wen_a = w; wmask_a = m; addr_a = a; wdata_a = d;
    endtask

    task automatic req_b(input logic v, input logic w, input logic [3:0] m, input logic [14:0] a, input logic [31:0] d);
        valid_b = v; wen_b = w; wmask_b = m; addr_b = a; wdata_b = d;
    endtask

    task automatic req_c(input logic v, input logic w, input logic [3:0] m, input logic [15:0] a, input logic [31:0] d);
        valid_c = v; wen_c = w; wmask_c = m; addr_c = a; wdata_c = d;
    endtask

    logic [31:0] bdat [4];

    initial begin
        bdat[0] = 32'h1000_0001; bdat[1] = 32'h2000_0002;
        bdat[2] = 32'h3000_0003; bdat[3] = 32'h4000_0004;

        tick();
        tick();
        check("rst_ready", {31'b0, ready_a}, 32'd1);
        check("rst_rvalid", {31'b0, rvalid_a}, 32'd0);
        check("rst_sleeping", {31'b0, sleeping_a}, 32'd0);
        check("rst_rdata_oreg", rdata_b, 32'h0);
        reset = 1'b0;

        // Bank aliasing, byte masks and back-to-back reads with unregistered output
        req_a(1, 1, 4'hF, 15'h0005, 32'hDEADBEEF); tick();
        check("wr_no_rvalid", {31'b0, rvalid_a}, 32'd0);
        req_a(1, 1, 4'hF, 15'h4005, 32'hCAFEF00D); tick();
        req_a(1, 1, 4'hF, 15'h0010, 32'h11223344); tick();
        req_a(1, 1, 4'b0101, 15'h0010, 32'hAABBCCDD); tick();
        req_a(1, 0, 4'h0, 15'h0005, 32'h0); tick();
        check("rd0_rvalid", {31'b0, rvalid_a}, 32'd1);
        check("rd0_data", rdata_a, 32'hDEADBEEF);
        req_a(1, 0, 4'h0, 15'h4005, 32'h0); tick();
        check("rd1_rvalid", {31'b0, rvalid_a}, 32'd1);
        check("rd1_data", rdata_a, 32'hCAFEF00D);
        req_a(1, 0, 4'h0, 15'h0010, 32'h0); tick();
        check("mask_data", rdata_a, 32'h11BB33DD);
        req_a(0, 0, 4'h0, 15'h0, 32'h0); tick();
        check("idle_rvalid", {31'b0, rvalid_a}, 32'd0);
        check("rdata_hold", rdata_a, 32'h11BB33DD);

        // Idle to sleep after 8 idle cycles, then wake sequence
        for (int i = 0; i < 6; i++) tick();
        check("pre_sleep", {31'b0, sleeping_a}, 32'd0);
        check("pre_sleep_ready", {31'b0, ready_a}, 32'd1);
        tick();
        check("sleep_entered", {31'b0, sleeping_a}, 32'd1);
        check("sleep_ready", {31'b0, ready_a}, 32'd0);
        req_a(1, 0, 4'h0, 15'h0005, 32'h0);
        tick();
        check("wake_sleeping", {31'b0, sleeping_a}, 32'd0);
        check("wake_ready0", {31'b0, ready_a}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("wake_ready%0d", i), {31'b0, ready_a}, 32'd0);
        end
        tick();
        check("wake_done_ready", {31'b0, ready_a}, 32'd1);
        check("wake_done_rvalid", {31'b0, rvalid_a}, 32'd0);
        tick();
        check("wake_rd_rvalid", {31'b0, rvalid_a}, 32'd1);
        check("wake_rd_data", rdata_a, 32'hDEADBEEF);
        req_a(0, 0, 4'h0, 15'h0, 32'h0);

        // Registered output: four pipelined reads return two cycles after acceptance
        for (int i = 0; i < 4; i++) begin
            req_b(1, 1, 4'hF, 15'(32'h20 + i), bdat[i]); tick();
        end
        for (int k = 0; k < 6; k++) begin
            if (k < 4) req_b(1, 0, 4'h0, 15'(32'h20 + k), 32'h0);
            else       req_b(0, 0, 4'h0, 15'h0, 32'h0);
            tick();
            if (k >= 1 && k <= 4) begin
                check($sformatf("oreg_rvalid%0d", k), {31'b0, rvalid_b}, 32'd1);
                check($sformatf("oreg_data%0d", k), rdata_b, bdat[k-1]);
            end else begin
                check($sformatf("oreg_rvalid%0d", k), {31'b0, rvalid_b}, 32'd0);
            end
        end
        check("oreg_hold", rdata_b, bdat[3]);

        // Reset between acceptance and rvalid cancels the pulse; also abandons sleep on dut_a
        req_b(1, 0, 4'h0, 15'h0020, 32'h0); tick();
        req_b(0, 0, 4'h0, 15'h0, 32'h0);
        check("a_asleep_before_rst", {31'b0, sleeping_a}, 32'd1);
        reset = 1'b1; tick();
        check("rst_cancel_rvalid", {31'b0, rvalid_b}, 32'd0);
        reset = 1'b0; tick();
        check("post_rst_rvalid", {31'b0, rvalid_b}, 32'd0);
        check("post_rst_ready", {31'b0, ready_b}, 32'd1);
        check("post_rst_a_sleep", {31'b0, sleeping_a}, 32'd0);
        check("post_rst_a_ready", {31'b0, ready_a}, 32'd1);

        // Three banks: index 3 is out of range
        req_c(1, 1, 4'hF, 16'h0000, 32'h12345678); tick();
        req_c(1, 1, 4'hF, 16'h8000, 32'h0BADF00D); tick();
        req_c(1, 0, 4'h0, 16'hC000, 32'h0); tick();
        check("oob_rvalid", {31'b0, rvalid_c}, 32'd1);
        check("oob_rdata", rdata_c, 32'h0);
        req_c(1, 1, 4'hF, 16'hC000, 32'hFFFFFFFF); tick();
        req_c(1, 0, 4'h0, 16'h0000, 32'h0); tick();
        check("oob_wr_dropped", rdata_c, 32'h12345678);
        req_c(1, 0, 4'h0, 16'h8000, 32'h0); tick();
        check("bank2_data", rdata_c, 32'h0BADF00D);
        req_c(0, 0, 4'h0, 16'h0, 32'h0); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
